// File: rtl/inner_product_pkg.sv
// rtl/inner_product_pkg.sv - shared constants and pair type for the inner-product datapath
//
// Purpose: default operand width / vector length used by the feeder and
//          the downstream inner-product pipeline, plus the packed pair type.
package inner_product_pkg;

    localparam int DATA_W_DEF  = 9;
    localparam int VEC_LEN_DEF = 4;
    localparam int DEPTH_DEF   = 8;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] a;
        logic [DATA_W_DEF-1:0] b;
    } pair_t;

endpackage

// File: rtl/pair_fifo.sv
// rtl/pair_fifo.sv - show-ahead synchronous FIFO of operand pairs
//
// Purpose: small buffer between the upstream handshake and the framing logic.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i / wdata_i    write request and pair (ignored while full)
//   pop_i               remove head (ignored while empty)
//   rdata_o             head pair, valid whenever !empty_o
//   full_o / empty_o    occupancy flags, purely registered
//   count_o             current occupancy 0..DEPTH
module pair_fifo
    import inner_product_pkg::*;
#(
    parameter type elem_t = pair_t,
    parameter int  DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  elem_t                    wdata_i,
    input  logic                     pop_i,
    output elem_t                    rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    elem_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // No bypass: a full FIFO never accepts, even when popping the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/inner_product_feeder.sv
// rtl/inner_product_feeder.sv - buffers (a,b) pairs and frames them into fixed-length vectors
//
// Purpose: upstream stage of pipelined_inner_product; one pair per cycle out,
//          with first/last markers and a count of completed vectors.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b    upstream pair handshake
//   out_valid/out_ready/out_a/out_b  pair handshake toward the pipeline
//   out_first/out_last             element 0 / element VEC_LEN-1 markers
//   vec_count                      completed vectors, wraps 255 -> 0
module inner_product_feeder
    import inner_product_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int VEC_LEN = VEC_LEN_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_first,
    output logic              out_last,
    output logic [7:0]        vec_count
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } feeder_pair_t;

    localparam int IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(VEC_LEN - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    feeder_pair_t            head;
    logic                    full, empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    push, pop;
    logic                    at_last;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7:0]              vec_count_q, vec_count_d;

    // Handshake readiness comes only from registered occupancy.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign at_last   = (idx_q == LAST_IDX);

    pair_fifo #(
        .elem_t (feeder_pair_t),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({in_a, in_b}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    // Framing advances only on actual pops, so stalls and bubbles are invisible to it.
    always_comb begin
        idx_d       = idx_q;
        vec_count_d = vec_count_q;
        if (pop) begin
            idx_d = at_last ? '0 : idx_q + IDX_ONE;
            if (at_last) vec_count_d = vec_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            vec_count_q <= '0;
        end else begin
            idx_q       <= idx_d;
            vec_count_q <= vec_count_d;
        end
    end

    // Data and markers are zeroed while nothing is presented.
    always_comb begin
        out_a     = out_valid ? head.a : '0;
        out_b     = out_valid ? head.b : '0;
        out_first = out_valid && (idx_q == '0);
        out_last  = out_valid && at_last;
        vec_count = vec_count_q;
    end

endmodule

// File: tb/tb_inner_product_feeder.sv
// tb/tb_inner_product_feeder.sv - self-checking bench for inner_product_feeder
module tb_inner_product_feeder;

    localparam int DW    = 9;
    localparam int VL    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_a, out_b;
    logic          out_first, out_last;
    logic [7:0]    vec_count;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered pairs and total number popped since reset.
    logic [2*DW-1:0] mq[$];
    int              popped = 0;

    inner_product_feeder #(.DATA_W(DW), .VEC_LEN(VL), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_first (out_first),
        .out_last  (out_last),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    wire [29:0] act_all = {out_valid, in_ready, out_a, out_b, out_first, out_last, vec_count};

    function automatic logic [29:0] exp_all();
        logic          v;
        logic [DW-1:0] a, b;
        v = (mq.size() != 0);
        a = v ? mq[0][2*DW-1:DW] : '0;
        b = v ? mq[0][DW-1:0] : '0;
        return {v, (mq.size() < DEPTH), a, b,
                v && (popped % VL == 0), v && (popped % VL == VL - 1),
                8'((popped / VL) % 256)};
    endfunction

    // Advance one clock, applying the handshake rules to the model.
    task automatic step();
        bit              pu, po;
        logic [2*DW-1:0] d;
        pu = in_valid && (mq.size() < DEPTH);
        po = out_ready && (mq.size() != 0);
        d  = {in_a, in_b};
        @(posedge clk);
        if (po) begin
            void'(mq.pop_front());
            popped++;
        end
        if (pu) mq.push_back(d);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        mq.delete();
        popped = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (act_all !== exp_all()) begin
            errors++; $display("FAIL reset_state act=%h exp=%h", act_all, exp_all());
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_flags act=%b%b exp=10", in_ready, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_a = DW'(i);
            in_b = DW'(i);
            step();
            checks++;
            if (act_all !== exp_all()) begin
                errors++; $display("FAIL basic_%0d act=%h exp=%h", i, act_all, exp_all());
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (vec_count !== 8'd1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_vec_count act=%0d/%b exp=1/0", vec_count, out_valid);
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_a = DW'($urandom);
            in_b = DW'($urandom);
            step();
            checks++;
            if (act_all !== exp_all()) begin
                errors++; $display("FAIL fill_%0d act=%h exp=%h", i, act_all, exp_all());
            end
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL full_in_ready act=%b exp=0", in_ready);
        end
        in_a = DW'($urandom);
        in_b = DW'($urandom);
        step();
        checks++;
        if (act_all !== exp_all()) begin
            errors++; $display("FAIL ninth_offer act=%h exp=%h", act_all, exp_all());
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (act_all !== exp_all()) begin
                errors++; $display("FAIL drain_%0d act=%h exp=%h", i, act_all, exp_all());
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty act=%b exp=0", out_valid);
        end
    endtask

    task automatic test_simul();
        int n;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = DW'($urandom);
            in_b = DW'($urandom);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_a = DW'($urandom);
            in_b = DW'($urandom);
            step();
            checks++;
            if (act_all !== exp_all() || in_ready !== 1'b1) begin
                errors++; $display("FAIL simul_%0d act=%h exp=%h", i, act_all, exp_all());
            end
        end
        in_valid = 1'b0;
        n = 0;
        while (out_valid && n < 20) begin
            n++;
            step();
        end
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL simul_occupancy act=%0d exp=4", n);
        end
    endtask

    task automatic test_stall();
        int guard;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_a = DW'($urandom);
            in_b = DW'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (popped % VL != 2 && guard < 8) begin
            guard++;
            step();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (act_all !== exp_all() || out_first !== 1'b0 || out_last !== 1'b0) begin
                errors++; $display("FAIL stall_%0d act=%h exp=%h", i, act_all, exp_all());
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_last !== 1'b1 || act_all !== exp_all()) begin
            errors++; $display("FAIL stall_last act=%h exp=%h", act_all, exp_all());
        end
        while (out_valid && guard < 30) begin
            guard++;
            step();
            checks++;
            if (act_all !== exp_all()) begin
                errors++; $display("FAIL stall_drain act=%h exp=%h", act_all, exp_all());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_a = DW'($urandom);
            in_b = DW'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (act_all !== exp_all()) begin
            errors++; $display("FAIL mid_before act=%h exp=%h", act_all, exp_all());
        end
        #2 rst_n = 1'b0;
        mq.delete();
        popped = 0;
        #1;
        checks++;
        if (act_all !== exp_all() || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset act=%h exp=%h", act_all, exp_all());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a = DW'($urandom);
        in_b = DW'($urandom);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_first !== 1'b1 || act_all !== exp_all()) begin
            errors++; $display("FAIL mid_first act=%h exp=%h", act_all, exp_all());
        end
        step();
    endtask

    task automatic test_stream();
        int sent, cyc;
        bit saw255;
        do_reset();
        sent = 0;
        cyc = 0;
        saw255 = 1'b0;
        out_ready = 1'b1;
        while (popped < 1024 && cyc < 1200) begin
            in_valid = (sent < 1024);
            in_a = DW'($urandom);
            in_b = DW'($urandom);
            if (in_valid && mq.size() < DEPTH) sent++;
            step();
            cyc++;
            if (vec_count == 8'd255) saw255 = 1'b1;
            checks++;
            if (act_all !== exp_all()) begin
                errors++; $display("FAIL stream_%0d act=%h exp=%h", cyc, act_all, exp_all());
            end
        end
        in_valid = 1'b0;
        checks++;
        if (cyc !== 1025) begin
            errors++; $display("FAIL stream_cycles act=%0d exp=1025", cyc);
        end
        checks++;
        if (vec_count !== 8'd0 || saw255 !== 1'b1) begin
            errors++; $display("FAIL stream_wrap act=%0d/%b exp=0/1", vec_count, saw255);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_a = DW'($urandom);
            in_b = DW'($urandom);
            step();
            checks++;
            if (act_all !== exp_all()) begin
                errors++; $display("FAIL random_%0d act=%h exp=%h", i, act_all, exp_all());
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_simul();
        test_stall();
        test_reset_mid();
        test_stream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inner_product_feeder.md
# inner_product_feeder

Upstream stage for `pipelined_inner_product`. Accepts element pairs (a, b) over a valid/ready handshake and buffers them in a small FIFO. Presents them to the inner-product pipeline one pair per cycle, framed into fixed-length vectors with first/last markers. Counts completed vectors, so the downstream accumulator knows where each dot product starts and ends.

## Interface
Parameters:
- `DATA_W`, 9: width of each operand; matches the inner-product input width.
- `VEC_LEN`, 4: elements per vector; legal range 2..256.
- `DEPTH`, 8: FIFO depth in pairs; power of two, at least 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  upstream pair present.
- `in_ready`  out  1  feeder can accept a pair this cycle.
- `in_a`  in  DATA_W  operand A.
- `in_b`  in  DATA_W  operand B.
- `out_valid`  out  1  pair presented to the inner-product stage.
- `out_ready`  in  1  inner-product stage consumes the pair this cycle.
- `out_a`  out  DATA_W  operand A to `inp1`.
- `out_b`  out  DATA_W  operand B to `inp2`.
- `out_first`  out  1  presented pair is element 0 of a vector.
- `out_last`  out  1  presented pair is element VEC_LEN-1.
- `vec_count`  out  8  completed vectors, wraps 255 -> 0.

## Operation
- Push: a pair is written when `in_valid && in_ready`.
  - `in_ready` = !full.
  - There is no bypass, so no push occurs while full, even if a pop happens that cycle.
- Pop: the FIFO is show-ahead.
  - `out_valid` = !empty.
  - `out_a`/`out_b` carry the head pair.
  - The head is removed when `out_valid && out_ready`.
- Data is forced to 0 when `out_valid` = 0.
- Occupancy:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Element index `idx` (0..VEC_LEN-1):
  - Increments on each pop.
  - Wraps to 0 after VEC_LEN-1.
- Framing outputs:
  - `out_first` = out_valid && idx==0.
  - `out_last` = out_valid && idx==VEC_LEN-1.
- `vec_count` increments on the pop that has `out_last` = 1.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from an occupancy counter of log2(DEPTH)+1 bits.
- Framing depends only on popped pairs. Stalls (`out_ready` = 0) and bubbles do not advance `idx`.

## Timing
- Reset values, asynchronous on `rst_n` low:
  - Pointers, occupancy, `idx` and `vec_count` = 0.
  - `out_valid` = 0, `out_first` = 0, `out_last` = 0.
  - `out_a` = 0, `out_b` = 0.
  - `in_ready` = 1.
  - FIFO contents are don't-care.
- Reset mid-vector discards buffered pairs and restarts framing at idx 0.
- Latency: a pair pushed at edge N into an empty FIFO is visible on `out_*` after edge N, i.e. one cycle.
- Throughput: one pair per cycle in steady state when `out_ready` is held high.
- While `out_valid && !out_ready`, `out_a`, `out_b`, `out_first` and `out_last` are held stable.
- `in_ready` and `out_valid` depend only on registered state, with no combinational path from `in_valid` or `out_ready`.
- Full: `in_ready` = 0 from the edge at which occupancy reaches DEPTH.
- Empty: `out_valid` = 0 from the edge at which occupancy reaches 0.

## Structure
- The shared package `inner_product_pkg` holds:
  - The default `DATA_W` and `VEC_LEN` constants.
  - A `pair_t` typedef (packed {a, b}).
- Sub-module `pair_fifo`:
  - Synchronous-write, show-ahead FIFO of `pair_t`.
  - Signals: push/pop/full/empty/count.
- The top holds the framing counter `idx`, `vec_count` and output gating.

## Test plan
- Reset, then push pairs (1,1),(2,2),(3,3),(4,4) with `out_ready` = 1 -> one cycle after each push, out emits them in order:
  - `out_first` on (1,1), `out_last` on (4,4).
  - `vec_count` = 1.
- Hold `out_ready` = 0 and push 8 pairs -> `in_ready` drops after the 8th push and the 9th offer is not accepted. Then release `out_ready` -> all 8 pairs emerge in order.
- With the FIFO at 4 entries, push and pop in the same cycle -> occupancy stays 4 and `in_ready` stays 1.
- Stall `out_ready` = 0 for 3 cycles on element 2 -> outputs stable, `idx` remains 2, and the subsequent `out_last` lands on the 4th popped pair.
- Assert `rst_n` low after 2 pops of a vector -> all outputs return to their reset values immediately. The next popped pair carries `out_first` = 1.
- Stream 1024 pairs continuously -> `vec_count` wraps 255 -> 0 after vector 256. No pair is lost or duplicated (compare against a scoreboard).
